three: RTL and testbench

- Registered 4-input threshold detector.
- Each accepted sample of x1..x4 is compared against THRESHOLD ones. The result f is 1 when at least THRESHOLD inputs are 1; at the default of 3, f is 1 when at least three of four inputs are high.
- Also reports the ones-count of the last sample and a saturating count of samples that produced f=1.
- Used as a small combinational-decision block with a clean registered boundary for downstream logic.

---
 rtl/three.sv | 69 ++++++
 tb/tb_three.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/three.sv
// Registered 4-input threshold detector.
// Each accepted sample {x1,x2,x3,x4} is reduced to its ones-count and compared
// against THRESHOLD. The decision, the count and a one-cycle valid strobe are
// registered. A saturating counter tracks how many accepted samples hit the
// threshold, with a synchronous clear that wins over a same-edge hit.
module three #(
    parameter int THRESHOLD = 3,   // legal range 0..4
    parameter int HIT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x1,
    input  logic             x2,
    input  logic             x3,
    input  logic             x4,
    input  logic             hit_clr,
    output logic             f,
    output logic [2:0]       ones_count,
    output logic             f_valid,
    output logic [HIT_W-1:0] hit_count
);

    // The threshold is held one bit wider than the count so that the "at
    // least THRESHOLD" test can be written as (cnt + 1) > THRESHOLD, which
    // stays a genuine comparison even when THRESHOLD is 0.
    localparam logic [3:0]       THR     = 4'(THRESHOLD);
    localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

    logic [2:0] cnt;
    logic       hit;

    // Ones-count of the current inputs and its threshold decision.
    always_comb begin
        cnt = {2'b00, x1} + {2'b00, x2} + {2'b00, x3} + {2'b00, x4};
        hit = ({1'b0, cnt} + 4'd1) > THR;
    end

    // Sample register: capture count and decision only on accepted samples,
    // so unknown inputs during idle cycles never reach the outputs.
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others; the async reset is in the
    // sensitivity list so outputs clear without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f          <= 1'b0;
            ones_count <= 3'd0;
            f_valid    <= 1'b0;
        end else begin
            f_valid <= in_valid;
            if (in_valid) begin
                f          <= hit;
                ones_count <= cnt;
            end
        end
    end

    // Saturating hit counter; a clear on the same edge drops that sample's hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (hit_clr) begin
            hit_count <= '0;
        end else if (in_valid && hit && (hit_count != HIT_MAX)) begin
            hit_count <= hit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_three.sv
// Self-checking bench for three. Four instances share one stimulus stream:
// default parameters, HIT_W=2 (saturation), THRESHOLD=0 and THRESHOLD=4.
// A behavioural model pushes the expected outputs of every instance into a
// per-instance queue when a sample is driven; the queues are popped and
// compared one time unit after the following rising edge.
module tb_three;

    localparam int N        = 4;
    localparam int THR[N]   = '{3, 3, 0, 4};
    localparam int HW[N]    = '{8, 2, 8, 8};

    typedef struct packed {
        logic       f;
        logic [2:0] oc;
        logic       fv;
        logic [7:0] hc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic x1, x2, x3, x4;
    logic hit_clr;

    logic       f0, f1, f2, f3;
    logic [2:0] oc0, oc1, oc2, oc3;
    logic       fv0, fv1, fv2, fv3;
    logic [7:0] hc0, hc2, hc3;
    logic [1:0] hc1;

    logic       obs_f [N];
    logic [2:0] obs_oc[N];
    logic       obs_fv[N];
    logic [7:0] obs_hc[N];

    exp_t sb[N][$];

    logic       m_f [N];
    logic [2:0] m_oc[N];
    logic       m_fv[N];
    int         m_hc[N];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    three #(.THRESHOLD(3), .HIT_W(8)) u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .hit_clr(hit_clr),
        .f(f0), .ones_count(oc0), .f_valid(fv0), .hit_count(hc0));

    three #(.THRESHOLD(3), .HIT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .hit_clr(hit_clr),
        .f(f1), .ones_count(oc1), .f_valid(fv1), .hit_count(hc1));

    three #(.THRESHOLD(0), .HIT_W(8)) u_thr0 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .hit_clr(hit_clr),
        .f(f2), .ones_count(oc2), .f_valid(fv2), .hit_count(hc2));

    three #(.THRESHOLD(4), .HIT_W(8)) u_thr4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .hit_clr(hit_clr),
        .f(f3), .ones_count(oc3), .f_valid(fv3), .hit_count(hc3));

    assign obs_f[0] = f0;  assign obs_oc[0] = oc0; assign obs_fv[0] = fv0; assign obs_hc[0] = hc0;
    assign obs_f[1] = f1;  assign obs_oc[1] = oc1; assign obs_fv[1] = fv1; assign obs_hc[1] = {6'd0, hc1};
    assign obs_f[2] = f2;  assign obs_oc[2] = oc2; assign obs_fv[2] = fv2; assign obs_hc[2] = hc2;
    assign obs_f[3] = f3;  assign obs_oc[3] = oc3; assign obs_fv[3] = fv3; assign obs_hc[3] = hc3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_f[i]  = 1'b0;
            m_oc[i] = 3'd0;
            m_fv[i] = 1'b0;
            m_hc[i] = 0;
            sb[i].delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s u%0d f", tag, i),  32'(obs_f[i]),  32'd0);
            check($sformatf("%s u%0d oc", tag, i), 32'(obs_oc[i]), 32'd0);
            check($sformatf("%s u%0d fv", tag, i), 32'(obs_fv[i]), 32'd0);
            check($sformatf("%s u%0d hc", tag, i), 32'(obs_hc[i]), 32'd0);
        end
    endtask

    task automatic compare_outputs(input string tag);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (sb[i].size() == 0) begin
                check($sformatf("%s u%0d sb_empty", tag, i), 32'd0, 32'd1);
            end else begin
                e = sb[i].pop_front();
                check($sformatf("%s u%0d f", tag, i),  32'(obs_f[i]),  32'(e.f));
                check($sformatf("%s u%0d oc", tag, i), 32'(obs_oc[i]), 32'(e.oc));
                check($sformatf("%s u%0d fv", tag, i), 32'(obs_fv[i]), 32'(e.fv));
                check($sformatf("%s u%0d hc", tag, i), 32'(obs_hc[i]), 32'(e.hc));
            end
        end
    endtask

    // Drive one cycle of stimulus, predict every instance, then compare.
    task automatic step(input string tag, input logic iv, input logic [3:0] xv, input logic clr);
        int pop;
        in_valid          = iv;
        {x1, x2, x3, x4}  = xv;
        hit_clr           = clr;
        for (int i = 0; i < N; i++) begin
            if (iv) begin
                pop = 0;
                for (int b = 0; b < 4; b++) if (xv[b] === 1'b1) pop++;
                m_oc[i] = 3'(pop);
                m_f[i]  = (pop >= THR[i]);
                m_fv[i] = 1'b1;
            end else begin
                m_fv[i] = 1'b0;
            end
            if (clr)
                m_hc[i] = 0;
            else if (iv && m_f[i] && m_hc[i] < (1 << HW[i]) - 1)
                m_hc[i]++;
            sb[i].push_back('{m_f[i], m_oc[i], m_fv[i], 8'(m_hc[i])});
        end
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        {x1, x2, x3, x4} = 4'b0000;
        hit_clr  = 1'b0;
        model_reset();
        #1;
        check_reset_state("reset_init");
        @(posedge clk); #1;
        rst = 1'b0;

        // Exhaustive sweep of all 16 codes.
        for (int v = 0; v < 16; v++)
            step($sformatf("sweep_%0d", v), 1'b1, 4'(v), 1'b0);
        check("sweep_total_hits", 32'(hc0), 32'd5);

        // Idle gaps, including unknown inputs while not valid.
        step("gap_1111", 1'b1, 4'b1111, 1'b0);
        step("gap_idle0", 1'b0, 4'b0000, 1'b0);
        step("gap_idle1", 1'b0, 4'b0000, 1'b0);
        step("gap_idle2", 1'b0, 4'b0000, 1'b0);
        step("gap_idle_x", 1'b0, 4'bxxxx, 1'b0);

        // Clear wins over a same-edge hit.
        step("clr_prio", 1'b1, 4'b1110, 1'b1);
        check("clr_prio_hc", 32'(hc0), 32'd0);
        check("clr_prio_f", 32'(f0), 32'd1);
        step("clr_after", 1'b1, 4'b1111, 1'b0);
        check("clr_after_hc", 32'(hc0), 32'd1);

        // Saturation on the HIT_W=2 instance: 1, 2, 3, 3, 3.
        step("sat_clr", 1'b0, 4'b0000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("sat_%0d", k), 1'b1, 4'b1111, 1'b0);
            check($sformatf("sat_%0d_hc", k), 32'(hc1), 32'((k < 3) ? k + 1 : 3));
        end

        // Parameter corners.
        step("thr_0000", 1'b1, 4'b0000, 1'b0);
        check("thr0_f_0000", 32'(f2), 32'd1);
        step("thr_1110", 1'b1, 4'b1110, 1'b0);
        check("thr4_f_1110", 32'(f3), 32'd0);
        step("thr_1111", 1'b1, 4'b1111, 1'b0);
        check("thr4_f_1111", 32'(f3), 32'd1);

        // Asynchronous reset between edges with a sample pending.
        in_valid         = 1'b1;
        {x1, x2, x3, x4} = 4'b1111;
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("reset_async");
        model_reset();
        @(posedge clk); #1;
        check_reset_state("reset_held");
        rst      = 1'b0;
        in_valid = 1'b0;

        // First samples after reset process normally.
        step("post_rst_1011", 1'b1, 4'b1011, 1'b0);
        step("post_rst_0001", 1'b1, 4'b0001, 1'b0);
        step("post_rst_idle", 1'b0, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
